pattern_scan_ctrl: RTL and testbench
====================================

# pattern_scan_ctrl

Sequencer for the Patterns `Counter` (step-adder: `out <= LoadVal + deltaX` one cycle after `cnt_enb`, `out` = 0 when not enabled). On a start request it drives `cnt_enb`, `Xmode` and `LoadVal` so that the Counter produces a run of addresses `start_addr`, `start_addr+d`, `start_addr+2d`, ... with d in {0,1,4,8}. It presents the run to a downstream consumer through a valid/ready handshake and sits between the pattern configuration registers and the Counter instance.

## Interface
- `ADDR_W`, 12: address width; must match the Counter width.
- `LEN_W`, 8: run-length width.
- `clk` in 1: master clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active low.
- `start` in 1: single-cycle run request; sampled only in IDLE.
- `start_addr` in ADDR_W: first address of the run; latched on start.
- `step_mode` in 2: step code, latched on start (00→0, 01→1, 10→4, 11→8).
- `run_len` in LEN_W: number of addresses in the run; latched on start.
- `abort` in 1: synchronous cancel of the run.
- `addr_rdy` in 1: consumer ready.
- `cnt_out` in ADDR_W: Counter `out`.
- `cnt_enb` out 1: Counter enable.
- `Xmode` out 2: Counter step select.
- `LoadVal` out ADDR_W: Counter base value.
- `addr_out` out ADDR_W: current address.
- `addr_vld` out 1: `addr_out` is valid.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at normal run completion.
- `wrap` out 1: sticky flag; the run crossed 2^ADDR_W. Cleared on the next accepted start.

## Operation
- States: IDLE, FIRST, RUN, DONE.
- IDLE:
  - `start`=1 latches config; `rem` <= `run_len`; `wrap` <= 0.
  - Next state is FIRST if `run_len`≠0, else DONE.
- FIRST:
  - `addr_out` = latched `start_addr`.
  - Then RUN on accept (`addr_vld`&`addr_rdy`), or DONE if this was the last beat.
- RUN: `addr_out` = `cnt_out`.
- Counter drive in FIRST/RUN:
  - `cnt_enb`=1 and `LoadVal`=`addr_out` (combinational).
  - `Xmode` = latched mode when the beat is accepted, else 00. Forcing 00 makes the Counter recirculate the same address during a stall.
- `addr_vld`=1 in FIRST/RUN.
- Each accept decrements `rem`. The accept with `rem`==1 is the last beat: next state is DONE.
- DONE:
  - `done`=1 and `busy`=0 for one cycle, `cnt_enb`=0, then IDLE.
  - `start` is ignored in DONE.
- `busy`=1 in FIRST/RUN.
- `abort` in FIRST/RUN: next state IDLE, no `done`, `cnt_enb`=0 next cycle. `abort` in IDLE/DONE has no effect.
- Wrap detection:
  - Arithmetic is modulo 2^ADDR_W, matching the Counter.
  - `wrap` is set when an accepted beat with d≠0 is followed by `cnt_out` < the accepted address.
  - With step 0, every beat equals `start_addr`.
- `start` while `busy` is ignored. Config inputs are don't-care outside the start cycle.

## Timing
- Reset values: `cnt_enb`=0, `Xmode`=00, `LoadVal`=0, `addr_out`=0, `addr_vld`=0, `busy`=0, `done`=0, `wrap`=0, state IDLE, `rem`=0.
- Reset asserted mid-run returns to IDLE immediately. No `done` is produced.
- `start` at cycle T → `addr_vld`=1 with `start_addr` at T+1.
- Throughput is 1 address/cycle with `addr_rdy` held high. An N-beat run occupies T+1..T+N, with `done` at T+N+1.
- Counter latency is 1 cycle. The beat accepted at cycle k yields the next address on `cnt_out` at k+1.
- Handshake rules: `addr_out` is stable while `addr_vld`&!`addr_rdy`, and `addr_vld` never drops without an accept except on abort or reset.
- `run_len`=0: `done` at T+1, with no `addr_vld`.

## Structure
- Shared `patterns_pkg`: step encodings ZERO/ONE/FOUR/EIGHT = 00/01/10/11, state enum, and default widths.
- The Counter is instantiated alongside this block by the parent; it is not instantiated inside.
- One natural sub-module: `beat_cnt`, the `rem` down-counter with load, decrement and last-beat flag.
- Target size: ~150–250 lines.

## Test plan
- Start with `start_addr`=0x010, mode 10, `run_len`=4, `addr_rdy`=1 → addresses 0x010, 0x014, 0x018, 0x01C on consecutive cycles; `done` one cycle later; `wrap`=0.
- Same run with `addr_rdy` low for 3 cycles on the 2nd beat → 0x014 held stable with `Xmode`=00 during the stall; sequence unchanged; `done` 3 cycles later.
- `start_addr`=0xFFC, mode 11, `run_len`=3 → 0xFFC, 0x004, 0x00C; `wrap`=1 after the 2nd beat; `wrap` cleared on the next start.
- `run_len`=0 → no `addr_vld`; `done` at T+1. Also `start` pulsed during a run → ignored, run unaffected.
- `abort` on the 3rd beat of an 8-beat run → IDLE next cycle, `cnt_enb`=0, no `done`. `rst_n` low mid-run → all outputs at reset values asynchronously.
- Mode 00, `run_len`=5, `start_addr`=0x123 → five beats of 0x123, `done`, `wrap`=0.

Source files
------------

// File: rtl/patterns_pkg.sv
// Shared definitions for the Patterns address sequencer: step codes, FSM states
// and default widths.
package patterns_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int LEN_W_DEF  = 8;

  // Counter step select: 00 -> +0, 01 -> +1, 10 -> +4, 11 -> +8.
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    ONE   = 2'b01,
    FOUR  = 2'b10,
    EIGHT = 2'b11
  } step_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FIRST = 2'b01,
    S_RUN   = 2'b10,
    S_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/pattern_scan_ctrl_beat_cnt.sv
// Remaining-beat down-counter for a scan run: loads the run length on start,
// decrements on each accepted beat and flags the final beat.
module beat_cnt #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [LEN_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [LEN_W-1:0] rem_q, rem_d;

  always_comb begin
    rem_d = rem_q;
    if (load_i) begin
      rem_d = load_val_i;
    end else if (dec_i && (rem_q != '0)) begin
      rem_d = rem_q - LEN_W'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign last_o = (rem_q == LEN_W'(1));

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Sequencer that drives the external step-adder Counter to produce an address
// run and presents it to a consumer over a valid/ready handshake.
module pattern_scan_ctrl
  import patterns_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [1:0]        step_mode,
  input  logic [LEN_W-1:0]  run_len,
  input  logic              abort,
  input  logic              addr_rdy,
  input  logic [ADDR_W-1:0] cnt_out,
  output logic              cnt_enb,
  output logic [1:0]        Xmode,
  output logic [ADDR_W-1:0] LoadVal,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_vld,
  output logic              busy,
  output logic              done,
  output logic              wrap
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  step_e             mode_q, mode_d;
  logic              wrap_q, wrap_d;
  logic [ADDR_W-1:0] acc_q, acc_d;
  logic              chk_q, chk_d;
  logic              load, accept, last;

  beat_cnt #(.LEN_W(LEN_W)) u_beat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .load_val_i (run_len),
    .dec_i      (accept),
    .last_o     (last)
  );

  // NOTE: every output and next-state variable gets a default before the case,
  // so no path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    mode_d   = mode_q;
    wrap_d   = wrap_q;
    acc_d    = acc_q;
    chk_d    = 1'b0;
    load     = 1'b0;
    accept   = 1'b0;
    cnt_enb  = 1'b0;
    Xmode    = ZERO;
    LoadVal  = '0;
    addr_out = '0;
    addr_vld = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    // The Counter result one cycle after a stepping accept is below the
    // accepted address only if the addition overflowed.
    if (chk_q && (cnt_out < acc_q)) begin
      wrap_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = start_addr;
          mode_d  = step_e'(step_mode);
          wrap_d  = 1'b0;
          load    = 1'b1;
          state_d = (run_len != '0) ? S_FIRST : S_DONE;
        end
      end

      S_FIRST, S_RUN: begin
        addr_out = (state_q == S_FIRST) ? base_q : cnt_out;
        addr_vld = 1'b1;
        busy     = 1'b1;
        cnt_enb  = 1'b1;
        LoadVal  = addr_out;
        accept   = addr_rdy;
        // A stall forces step 0 so the Counter recirculates the current address.
        if (accept) begin
          Xmode = mode_q;
          acc_d = addr_out;
          chk_d = (mode_q != ZERO);
        end
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept) begin
          state_d = last ? S_DONE : S_RUN;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      mode_q  <= ZERO;
      wrap_q  <= 1'b0;
      acc_q   <= '0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      acc_q   <= acc_d;
      chk_q   <= chk_d;
    end
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl with a behavioural model of the Counter.
module tb_pattern_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] start_addr;
  logic [1:0]  step_mode;
  logic [7:0]  run_len;
  logic        abort;
  logic        addr_rdy;
  logic [11:0] cnt_out;
  logic        cnt_enb;
  logic [1:0]  Xmode;
  logic [11:0] LoadVal;
  logic [11:0] addr_out;
  logic        addr_vld;
  logic        busy;
  logic        done;
  logic        wrap;

  int n_vec = 0;
  int n_err = 0;

  pattern_scan_ctrl #(.ADDR_W(12), .LEN_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .step_mode  (step_mode),
    .run_len    (run_len),
    .abort      (abort),
    .addr_rdy   (addr_rdy),
    .cnt_out    (cnt_out),
    .cnt_enb    (cnt_enb),
    .Xmode      (Xmode),
    .LoadVal    (LoadVal),
    .addr_out   (addr_out),
    .addr_vld   (addr_vld),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counter: out <= LoadVal + delta one cycle after cnt_enb, 0 when disabled.
  logic [11:0] delta;
  always_comb begin
    case (Xmode)
      2'b00:   delta = 12'd0;
      2'b01:   delta = 12'd1;
      2'b10:   delta = 12'd4;
      default: delta = 12'd8;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_out <= '0;
    else if (cnt_enb) cnt_out <= LoadVal + delta;
    else              cnt_out <= '0;
  end

  typedef struct {
    logic        start;
    logic [11:0] saddr;
    logic [1:0]  step;
    logic [7:0]  len;
    logic        abort;
    logic        rdy;
    logic        vld;
    logic [11:0] addr;
    logic        busy;
    logic        done;
    logic        wrap;
    logic        enb;
    logic [1:0]  xm;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int st, int sa, int sm, int ln, int ab, int rd,
                              int vl, int ad, int bs, int dn, int wr, int en, int xm);
    vec_t v;
    v.start = st[0];   v.saddr = 12'(sa); v.step = 2'(sm);  v.len = 8'(ln);
    v.abort = ab[0];   v.rdy   = rd[0];   v.vld  = vl[0];   v.addr = 12'(ad);
    v.busy  = bs[0];   v.done  = dn[0];   v.wrap = wr[0];   v.enb  = en[0];
    v.xm    = 2'(xm);
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {vld, addr, busy, done, wrap, enb, Xmode, LoadVal}
  function automatic logic [63:0] pack_out();
    return 64'({addr_vld, addr_out, busy, done, wrap, cnt_enb, Xmode, LoadVal});
  endfunction

  function automatic logic [63:0] pack_exp(vec_t v);
    logic [11:0] ld;
    ld = v.enb ? v.addr : 12'h000;
    return 64'({v.vld, v.addr, v.busy, v.done, v.wrap, v.enb, v.xm, ld});
  endfunction

  task automatic idle_inputs();
    start = 1'b0; start_addr = '0; step_mode = '0; run_len = '0; abort = 1'b0;
  endtask

  initial begin
    // Run 0x010, step 4, four beats, always ready.
    add(1,'h010,2,4,0,1, 0,'h000,0,0,0,0,0);
    add(0,0,0,0,0,1,     1,'h010,1,0,0,1,2);
    add(0,0,0,0,0,1,     1,'h014,1,0,0,1,2);
    add(0,0,0,0,0,1,     1,'h018,1,0,0,1,2);
    add(0,0,0,0,0,1,     1,'h01C,1,0,0,1,2);
    add(0,0,0,0,0,1,     0,'h000,0,1,0,0,0);
    add(0,0,0,0,0,1,     0,'h000,0,0,0,0,0);
    // Same run with a 3-cycle stall on beat 2 and an ignored start mid-run.
    add(1,'h010,2,4,0,1, 0,'h000,0,0,0,0,0);
    add(0,0,0,0,0,1,     1,'h010,1,0,0,1,2);
    add(1,'h555,3,2,0,0, 1,'h014,1,0,0,1,0);
    add(0,0,0,0,0,0,     1,'h014,1,0,0,1,0);
    add(0,0,0,0,0,0,     1,'h014,1,0,0,1,0);
    add(0,0,0,0,0,1,     1,'h014,1,0,0,1,2);
    add(0,0,0,0,0,1,     1,'h018,1,0,0,1,2);
    add(0,0,0,0,0,1,     1,'h01C,1,0,0,1,2);
    add(0,0,0,0,0,1,     0,'h000,0,1,0,0,0);
    add(0,0,0,0,0,1,     0,'h000,0,0,0,0,0);
    // Wrap across 0x1000, then a zero-length start that clears it.
    add(1,'hFFC,3,3,0,1, 0,'h000,0,0,0,0,0);
    add(0,0,0,0,0,1,     1,'hFFC,1,0,0,1,3);
    add(0,0,0,0,0,1,     1,'h004,1,0,0,1,3);
    add(0,0,0,0,0,1,     1,'h00C,1,0,1,1,3);
    add(0,0,0,0,0,1,     0,'h000,0,1,1,0,0);
    add(1,'h300,1,0,0,1, 0,'h000,0,0,1,0,0);
    add(0,0,0,0,0,1,     0,'h000,0,1,0,0,0);
    add(0,0,0,0,0,1,     0,'h000,0,0,0,0,0);
    // Step 0: five identical beats.
    add(1,'h123,0,5,0,1, 0,'h000,0,0,0,0,0);
    add(0,0,0,0,0,1,     1,'h123,1,0,0,1,0);
    add(0,0,0,0,0,1,     1,'h123,1,0,0,1,0);
    add(0,0,0,0,0,1,     1,'h123,1,0,0,1,0);
    add(0,0,0,0,0,1,     1,'h123,1,0,0,1,0);
    add(0,0,0,0,0,1,     1,'h123,1,0,0,1,0);
    add(0,0,0,0,0,1,     0,'h000,0,1,0,0,0);
    add(0,0,0,0,0,1,     0,'h000,0,0,0,0,0);
    // Abort on beat 3 of 8: back to idle, no done.
    add(1,'h100,1,8,0,1, 0,'h000,0,0,0,0,0);
    add(0,0,0,0,0,1,     1,'h100,1,0,0,1,1);
    add(0,0,0,0,0,1,     1,'h101,1,0,0,1,1);
    add(0,0,0,0,1,1,     1,'h102,1,0,0,1,1);
    add(0,0,0,0,0,1,     0,'h000,0,0,0,0,0);
    add(0,0,0,0,0,1,     0,'h000,0,0,0,0,0);
    // Abort in idle is ignored; single-beat run.
    add(1,'h040,2,1,1,1, 0,'h000,0,0,0,0,0);
    add(0,0,0,0,0,1,     1,'h040,1,0,0,1,2);
    add(0,0,0,0,0,1,     0,'h000,0,1,0,0,0);
    add(0,0,0,0,0,1,     0,'h000,0,0,0,0,0);

    idle_inputs();
    addr_rdy = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_values", pack_out(), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      start = vecs[i].start; start_addr = vecs[i].saddr; step_mode = vecs[i].step;
      run_len = vecs[i].len; abort = vecs[i].abort; addr_rdy = vecs[i].rdy;
      #1 check($sformatf("vec%0d", i), pack_out(), pack_exp(vecs[i]));
    end

    // Random back-pressure, step 1, six beats from 0x200.
    begin
      logic [11:0] exp_addr, prev_addr;
      logic        prev_stall;
      int          beats;
      bit          got_done;
      exp_addr = 12'h200; prev_stall = 1'b0; prev_addr = '0; beats = 0; got_done = 0;
      @(negedge clk);
      start = 1'b1; start_addr = 12'h200; step_mode = 2'b01; run_len = 8'd6; addr_rdy = 1'b0;
      for (int c = 0; c < 100 && !got_done; c++) begin
        @(negedge clk);
        idle_inputs();
        addr_rdy = (c % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        #1;
        if (addr_vld && prev_stall) check("stall_hold", 64'(addr_out), 64'(prev_addr));
        if (addr_vld && !addr_rdy)  check("stall_xmode", 64'(Xmode), 64'd0);
        if (addr_vld && addr_rdy) begin
          check($sformatf("bp_beat%0d", beats), 64'(addr_out), 64'(exp_addr));
          exp_addr = exp_addr + 12'd1;
          beats++;
        end
        prev_stall = addr_vld && !addr_rdy;
        prev_addr  = addr_out;
        if (done) got_done = 1;
      end
      check("bp_done_seen", 64'(got_done), 64'd1);
      check("bp_beat_count", 64'(beats), 64'd6);
    end

    // Asynchronous reset mid-run after wrap has been set.
    @(negedge clk);
    idle_inputs(); addr_rdy = 1'b1;
    start = 1'b1; start_addr = 12'hFFC; step_mode = 2'b11; run_len = 8'd8;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    #1 check("wrap_before_reset", 64'({wrap, busy}), 64'b11);
    #1 rst_n = 1'b0;
    #1 check("async_reset", pack_out(), 64'd0);
    begin
      bit saw_done;
      saw_done = 0;
      repeat (3) begin
        @(negedge clk);
        #1 if (done || addr_vld) saw_done = 1;
      end
      rst_n = 1'b1;
      repeat (3) begin
        @(negedge clk);
        #1 if (done || addr_vld) saw_done = 1;
      end
      check("no_done_after_reset", 64'(saw_done), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
